mem_seq_controller: RTL and testbench
=====================================

Name: mem_seq_controller

Overview:
- Sequencing controller for the memory stage.
- Takes one decoded memory operation per handshake, plus a hardware interrupt request. Expands multi-cycle ops (CALL, RET, RTI, interrupt entry) into per-cycle micro-ops.
- Drives the memory stage controls: read/write/push/pop, address select, write-source select, pc_choose_memory, interrupt.
- Holds the upstream pipeline via stall until the sequence ends.

Parameters:
- STACK_DEPTH, 1024: number of 16-bit stack entries; matches the data-memory size.
- CNT_W, 11: width of the stack occupancy counter; must hold 0..STACK_DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation offered.
- op_code  in  3  000 NOP, 001 PUSH, 010 POP, 011 LOAD, 100 STORE, 101 CALL, 110 RET, 111 RTI.
- irq  in  1  interrupt request; level, sampled each cycle.
- op_ready  out  1  controller accepts op_code this cycle.
- stall  out  1  freeze the fetch/decode/execute stages.
- done  out  1  last micro-op of the accepted operation is issuing.
- memory_read, memory_write, memory_push, memory_pop  out  1 each  memory stage controls.
- memory_address_select  out  2  00 std_address, 01 ldd_address, 10 sp.
- memory_write_src_select  out  2  00 flags, 01 PC[31:16], 10 PC[15:0], 11 register data.
- pc_choose_memory  out  1  PC taken from the memory shift register.
- interrupt  out  1  force PC to 0.
- flags_restore  out  1  memory data this cycle holds the saved flags.
- stack_fault  out  1  sticky overflow/underflow flag (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; irq_pending clears.
  - All outputs are 0 except op_ready=1.
  - Stack count goes to 0.
- Accept: an op is accepted when op_valid & op_ready. op_ready=1 only in IDLE with irq_pending=0.
- First micro-op timing: the first micro-op of every op is driven combinationally in the accept cycle (Mealy). Later micro-ops are driven as Moore decode of state.
- irq handling:
  - irq=1 in any cycle sets irq_pending.
  - In IDLE with irq_pending=1, the controller starts INT instead of accepting; irq_pending clears on entry.
  - An irq during a sequence is served right after done; no op is accepted in between.
- Single-cycle ops (done=1 and stall=0 in the accept cycle; state stays IDLE):
  - PUSH: write=1, push=1, addr=10, src=11.
  - POP: read=1, pop=1, addr=10.
  - LOAD: read=1, addr=01.
  - STORE: write=1, addr=00, src=11.
  - NOP: all controls 0, done=1.
- CALL (2 cycles):
  - c0 PUSH_PCU: write, push, addr=10, src=01.
  - c1 PUSH_PCL: src=10, done.
- RET (3 cycles):
  - c0 POP_PCL: read, pop, addr=10.
  - c1 POP_PCU: same controls.
  - c2 RET_JUMP: pc_choose_memory=1, done.
- RTI (3 cycles):
  - c0 POP_PCL, c1 POP_PCU: as in RET.
  - c2 POP_FLAGS: read, pop, addr=10, pc_choose_memory=1, flags_restore=1, done.
- INT (4 cycles):
  - c0 PUSH_FLAGS: src=00.
  - c1 PUSH_PCU: src=01.
  - c2 PUSH_PCL: src=10.
  - c0..c2 all drive write, push, addr=10.
  - c3 INT_JUMP: interrupt=1, done.
- stall: 1 in every cycle of a multi-cycle sequence except the done cycle.
- Don't-care selects: memory_address_select and memory_write_src_select are 00 whenever their enabling strobe is 0.
- op_valid while busy: ignored and not buffered. Upstream must hold the op while stalled.
- Reset mid-sequence: aborts immediately; no partial micro-op is issued after the reset.

Optional Feature:
- Macro MEM_SEQ_STACK_CHECK_EN.
- When defined:
  - A CNT_W-bit occupancy counter increments on each issued push and decrements on each issued pop.
  - A push at count==STACK_DEPTH, or a pop at count==0, sets stack_fault (sticky until reset).
  - The faulting micro-op's push/pop and write/read strobes are forced to 0.
  - The sequence still advances and completes with done.
- When undefined: no counter; stack_fault is tied to 0; strobes are never suppressed.

Test Plan:
- Reset low mid-INT (state PUSH_PCU) -> next cycle all strobes 0, op_ready=1, stall=0; after release, a PUSH issues normally.
- CALL accepted -> c0: write=1, push=1, addr=10, src=01, stall=1; c1: src=10, done=1, stall=0; c2 op_ready=1.
- RET after CALL of PC 0x0001_0024 (memory model attached) -> c2: pc_choose_memory=1, final PC 0x0001_0024, done=1.
- irq pulsed during the RET c1 cycle, with op_valid=1 held -> RET completes; next cycle INT starts (src=00); interrupt=1 at INT c3; the held op is accepted the cycle after.
- RTI -> c2: read=1, pop=1, flags_restore=1, pc_choose_memory=1, done=1; three pops total.
- MEM_SEQ_STACK_CHECK_EN, POP with count=0 -> stack_fault=1, read=0, pop=0, done=1; stack_fault stays 1 until reset.

Source files
------------

// File: rtl/mem_seq_controller.sv
// Memory-stage sequencer: expands CALL/RET/RTI/interrupt entry into per-cycle stack micro-ops.
// Optional stack occupancy checking is enabled by defining MEM_SEQ_STACK_CHECK_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | accepting ops; single-cycle ops and every first micro-op issue here
// S_CALL_PCL  | CALL c1: push PC[15:0], done
// S_RET_PCU   | RET c1: pop PC[31:16]
// S_RET_JUMP  | RET c2: load PC from memory shift register, done
// S_RTI_PCU   | RTI c1: pop PC[31:16]
// S_RTI_FLAGS | RTI c2: pop flags, load PC, done
// S_INT_PCU   | INT c1: push PC[31:16]
// S_INT_PCL   | INT c2: push PC[15:0]
// S_INT_JUMP  | INT c3: force PC to 0, done

module mem_seq_controller #(
  parameter int STACK_DEPTH = 1024,
  parameter int CNT_W       = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  input  logic [2:0] op_code,
  input  logic       irq,
  output logic       op_ready,
  output logic       stall,
  output logic       done,
  output logic       memory_read,
  output logic       memory_write,
  output logic       memory_push,
  output logic       memory_pop,
  output logic [1:0] memory_address_select,
  output logic [1:0] memory_write_src_select,
  output logic       pc_choose_memory,
  output logic       interrupt,
  output logic       flags_restore,
  output logic       stack_fault
);

  localparam logic [2:0] OPC_NOP   = 3'b000;
  localparam logic [2:0] OPC_PUSH  = 3'b001;
  localparam logic [2:0] OPC_POP   = 3'b010;
  localparam logic [2:0] OPC_LOAD  = 3'b011;
  localparam logic [2:0] OPC_STORE = 3'b100;
  localparam logic [2:0] OPC_CALL  = 3'b101;
  localparam logic [2:0] OPC_RET   = 3'b110;
  localparam logic [2:0] OPC_RTI   = 3'b111;

  localparam logic [1:0] ADDR_STD = 2'b00;
  localparam logic [1:0] ADDR_LDD = 2'b01;
  localparam logic [1:0] ADDR_SP  = 2'b10;

  localparam logic [1:0] SRC_FLAGS = 2'b00;
  localparam logic [1:0] SRC_PCU   = 2'b01;
  localparam logic [1:0] SRC_PCL   = 2'b10;
  localparam logic [1:0] SRC_REG   = 2'b11;

  if (CNT_W < $clog2(STACK_DEPTH + 1)) begin : g_cnt_w_check
    $error("mem_seq_controller: CNT_W cannot hold STACK_DEPTH");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_CALL_PCL,
    S_RET_PCU,
    S_RET_JUMP,
    S_RTI_PCU,
    S_RTI_FLAGS,
    S_INT_PCU,
    S_INT_PCL,
    S_INT_JUMP
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       irq_pending;
  logic       int_start;

  logic       rd_raw;
  logic       wr_raw;
  logic       push_raw;
  logic       pop_raw;
  logic [1:0] addr_raw;
  logic [1:0] src_raw;
  logic       suppress;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      irq_pending <= 1'b0;
    end else begin
      state       <= next_state;
      irq_pending <= irq | (irq_pending & ~int_start);
    end
  end

  // Micro-op decode: IDLE is Mealy on op_valid/op_code, all other states are Moore.
  always_comb begin
    next_state       = state;
    int_start        = 1'b0;
    op_ready         = (state == S_IDLE) && !irq_pending;
    stall            = 1'b0;
    done             = 1'b0;
    rd_raw           = 1'b0;
    wr_raw           = 1'b0;
    push_raw         = 1'b0;
    pop_raw          = 1'b0;
    addr_raw         = ADDR_STD;
    src_raw          = SRC_FLAGS;
    pc_choose_memory = 1'b0;
    interrupt        = 1'b0;
    flags_restore    = 1'b0;

    if (reset) begin
      unique case (state)
        S_IDLE: begin
          if (irq_pending) begin
            int_start  = 1'b1;
            stall      = 1'b1;
            wr_raw     = 1'b1;
            push_raw   = 1'b1;
            addr_raw   = ADDR_SP;
            src_raw    = SRC_FLAGS;
            next_state = S_INT_PCU;
          end else if (op_valid) begin
            case (op_code)
              OPC_NOP: begin
                done = 1'b1;
              end
              OPC_PUSH: begin
                wr_raw   = 1'b1;
                push_raw = 1'b1;
                addr_raw = ADDR_SP;
                src_raw  = SRC_REG;
                done     = 1'b1;
              end
              OPC_POP: begin
                rd_raw   = 1'b1;
                pop_raw  = 1'b1;
                addr_raw = ADDR_SP;
                done     = 1'b1;
              end
              OPC_LOAD: begin
                rd_raw   = 1'b1;
                addr_raw = ADDR_LDD;
                done     = 1'b1;
              end
              OPC_STORE: begin
                wr_raw   = 1'b1;
                addr_raw = ADDR_STD;
                src_raw  = SRC_REG;
                done     = 1'b1;
              end
              OPC_CALL: begin
                wr_raw     = 1'b1;
                push_raw   = 1'b1;
                addr_raw   = ADDR_SP;
                src_raw    = SRC_PCU;
                stall      = 1'b1;
                next_state = S_CALL_PCL;
              end
              OPC_RET: begin
                rd_raw     = 1'b1;
                pop_raw    = 1'b1;
                addr_raw   = ADDR_SP;
                stall      = 1'b1;
                next_state = S_RET_PCU;
              end
              OPC_RTI: begin
                rd_raw     = 1'b1;
                pop_raw    = 1'b1;
                addr_raw   = ADDR_SP;
                stall      = 1'b1;
                next_state = S_RTI_PCU;
              end
              default: begin
                done = 1'b0;
              end
            endcase
          end
        end
        S_CALL_PCL: begin
          wr_raw     = 1'b1;
          push_raw   = 1'b1;
          addr_raw   = ADDR_SP;
          src_raw    = SRC_PCL;
          done       = 1'b1;
          next_state = S_IDLE;
        end
        S_RET_PCU: begin
          rd_raw     = 1'b1;
          pop_raw    = 1'b1;
          addr_raw   = ADDR_SP;
          stall      = 1'b1;
          next_state = S_RET_JUMP;
        end
        S_RET_JUMP: begin
          pc_choose_memory = 1'b1;
          done             = 1'b1;
          next_state       = S_IDLE;
        end
        S_RTI_PCU: begin
          rd_raw     = 1'b1;
          pop_raw    = 1'b1;
          addr_raw   = ADDR_SP;
          stall      = 1'b1;
          next_state = S_RTI_FLAGS;
        end
        S_RTI_FLAGS: begin
          rd_raw           = 1'b1;
          pop_raw          = 1'b1;
          addr_raw         = ADDR_SP;
          pc_choose_memory = 1'b1;
          flags_restore    = 1'b1;
          done             = 1'b1;
          next_state       = S_IDLE;
        end
        S_INT_PCU: begin
          wr_raw     = 1'b1;
          push_raw   = 1'b1;
          addr_raw   = ADDR_SP;
          src_raw    = SRC_PCU;
          stall      = 1'b1;
          next_state = S_INT_PCL;
        end
        S_INT_PCL: begin
          wr_raw     = 1'b1;
          push_raw   = 1'b1;
          addr_raw   = ADDR_SP;
          src_raw    = SRC_PCL;
          stall      = 1'b1;
          next_state = S_INT_JUMP;
        end
        S_INT_JUMP: begin
          interrupt  = 1'b1;
          done       = 1'b1;
          next_state = S_IDLE;
        end
        default: begin
          next_state = S_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_SEQ_STACK_CHECK_EN
  logic [CNT_W-1:0] stack_cnt;
  logic             overflow;
  logic             underflow;
  logic             fault_q;

  assign overflow  = push_raw && (stack_cnt == CNT_W'(STACK_DEPTH));
  assign underflow = pop_raw && (stack_cnt == '0);
  assign suppress  = overflow | underflow;

  // Faulting micro-ops are dropped, so the count never leaves 0..STACK_DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stack_cnt <= '0;
      fault_q   <= 1'b0;
    end else begin
      if (push_raw && !overflow) begin
        stack_cnt <= stack_cnt + CNT_W'(1);
      end else if (pop_raw && !underflow) begin
        stack_cnt <= stack_cnt - CNT_W'(1);
      end
      if (suppress) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign stack_fault = fault_q | suppress;
`else
  assign suppress    = 1'b0;
  assign stack_fault = 1'b0;
`endif

  assign memory_read  = rd_raw & ~suppress;
  assign memory_write = wr_raw & ~suppress;
  assign memory_push  = push_raw & ~suppress;
  assign memory_pop   = pop_raw & ~suppress;

  assign memory_address_select   = (memory_read | memory_write) ? addr_raw : 2'b00;
  assign memory_write_src_select = memory_write ? src_raw : 2'b00;

endmodule

// File: tb/tb_mem_seq_controller.sv
// Directed bench for mem_seq_controller with a small stack/PC memory model on the strobes.
module tb_mem_seq_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'b000;
  logic        irq = 1'b0;
  logic        op_ready, stall, done;
  logic        memory_read, memory_write, memory_push, memory_pop;
  logic [1:0]  memory_address_select, memory_write_src_select;
  logic        pc_choose_memory, interrupt, flags_restore, stack_fault;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] OPC_NOP   = 3'b000;
  localparam logic [2:0] OPC_PUSH  = 3'b001;
  localparam logic [2:0] OPC_POP   = 3'b010;
  localparam logic [2:0] OPC_LOAD  = 3'b011;
  localparam logic [2:0] OPC_STORE = 3'b100;
  localparam logic [2:0] OPC_CALL  = 3'b101;
  localparam logic [2:0] OPC_RET   = 3'b110;
  localparam logic [2:0] OPC_RTI   = 3'b111;

  // Packed view of every output: {op_ready, stall, done, rd, wr, push, pop, addr, src, pcm, int, fr, sf}
  localparam logic [14:0] OPR   = 15'h4000;
  localparam logic [14:0] STL   = 15'h2000;
  localparam logic [14:0] DN    = 15'h1000;
  localparam logic [14:0] RD    = 15'h0800;
  localparam logic [14:0] WR    = 15'h0400;
  localparam logic [14:0] PSH   = 15'h0200;
  localparam logic [14:0] POP   = 15'h0100;
  localparam logic [14:0] A_SP  = 15'h0080;
  localparam logic [14:0] A_LDD = 15'h0040;
  localparam logic [14:0] S_PCU = 15'h0010;
  localparam logic [14:0] S_PCL = 15'h0020;
  localparam logic [14:0] S_REG = 15'h0030;
  localparam logic [14:0] PCM   = 15'h0008;
  localparam logic [14:0] INTR  = 15'h0004;
  localparam logic [14:0] FR    = 15'h0002;
  localparam logic [14:0] SF    = 15'h0001;

  logic [14:0] ctl;
  assign ctl = {op_ready, stall, done, memory_read, memory_write, memory_push, memory_pop,
                memory_address_select, memory_write_src_select,
                pc_choose_memory, interrupt, flags_restore, stack_fault};

  logic [31:0] pc_value   = 32'h0000_0000;
  logic [15:0] flags_value = 16'h00A5;
  logic [15:0] reg_data   = 16'h1234;
  logic [15:0] model_stack[$];
  logic [31:0] pc_sr = 32'h0;
  logic [15:0] flags_sr = 16'h0;
  int          pop_total = 0;

  mem_seq_controller #(.STACK_DEPTH(1024), .CNT_W(11)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .op_valid                (op_valid),
    .op_code                 (op_code),
    .irq                     (irq),
    .op_ready                (op_ready),
    .stall                   (stall),
    .done                    (done),
    .memory_read             (memory_read),
    .memory_write            (memory_write),
    .memory_push             (memory_push),
    .memory_pop              (memory_pop),
    .memory_address_select   (memory_address_select),
    .memory_write_src_select (memory_write_src_select),
    .pc_choose_memory        (pc_choose_memory),
    .interrupt               (interrupt),
    .flags_restore           (flags_restore),
    .stack_fault             (stack_fault)
  );

  always #5 clk = ~clk;

  // Memory model: stack of 16-bit words and the PC/flags shift registers fed by pops.
  always @(posedge clk) begin
    if (!reset) begin
      model_stack.delete();
    end else begin
      if (memory_write && memory_push) begin
        case (memory_write_src_select)
          2'b00:   model_stack.push_back(flags_value);
          2'b01:   model_stack.push_back(pc_value[31:16]);
          2'b10:   model_stack.push_back(pc_value[15:0]);
          default: model_stack.push_back(reg_data);
        endcase
      end
      if (memory_read && memory_pop) begin
        pop_total <= pop_total + 1;
        if (model_stack.size() == 0) begin
          pc_sr <= {16'hDEAD, pc_sr[31:16]};
        end else if (flags_restore) begin
          flags_sr <= model_stack.pop_back();
        end else begin
          pc_sr <= {model_stack.pop_back(), pc_sr[31:16]};
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (ctl !== OPR) begin n_fail++; $display("FAIL reset_hold: got %h want %h", ctl, OPR); end
    step();
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctl !== OPR) begin n_fail++; $display("FAIL reset_idle: got %h want %h", ctl, OPR); end
  endtask

  task automatic test_single();
    logic [2:0]  ops[5];
    logic [14:0] exps[5];
    ops[0] = OPC_PUSH;  exps[0] = OPR | DN | WR | PSH | A_SP | S_REG;
    ops[1] = OPC_POP;   exps[1] = OPR | DN | RD | POP | A_SP;
    ops[2] = OPC_LOAD;  exps[2] = OPR | DN | RD | A_LDD;
    ops[3] = OPC_STORE; exps[3] = OPR | DN | WR | S_REG;
    ops[4] = OPC_NOP;   exps[4] = OPR | DN;
    for (int i = 0; i < 5; i++) begin
      step();
      op_valid = 1'b1;
      op_code  = ops[i];
      @(negedge clk);
      n_tests++;
      if (ctl !== exps[i]) begin
        n_fail++;
        $display("FAIL single_op%0d: got %h want %h", ops[i], ctl, exps[i]);
      end
    end
    step();
    op_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ctl !== OPR) begin n_fail++; $display("FAIL idle_no_op: got %h want %h", ctl, OPR); end
  endtask

  task automatic test_call();
    pc_value = 32'h0001_0024;
    step();
    op_valid = 1'b1;
    op_code  = OPC_CALL;
    @(negedge clk);
    n_tests++;
    if (ctl !== (OPR | STL | WR | PSH | A_SP | S_PCU)) begin
      n_fail++; $display("FAIL call_c0: got %h want %h", ctl, OPR | STL | WR | PSH | A_SP | S_PCU);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (ctl !== (DN | WR | PSH | A_SP | S_PCL)) begin
      n_fail++; $display("FAIL call_c1: got %h want %h", ctl, DN | WR | PSH | A_SP | S_PCL);
    end
    step();
    op_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ctl !== OPR) begin n_fail++; $display("FAIL call_c2: got %h want %h", ctl, OPR); end
  endtask

  task automatic test_ret();
    pc_value = 32'h0BAD_F00D;
    step();
    op_valid = 1'b1;
    op_code  = OPC_RET;
    @(negedge clk);
    n_tests++;
    if (ctl !== (OPR | STL | RD | POP | A_SP)) begin
      n_fail++; $display("FAIL ret_c0: got %h want %h", ctl, OPR | STL | RD | POP | A_SP);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (ctl !== (STL | RD | POP | A_SP)) begin
      n_fail++; $display("FAIL ret_c1: got %h want %h", ctl, STL | RD | POP | A_SP);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (ctl !== (DN | PCM)) begin n_fail++; $display("FAIL ret_c2: got %h want %h", ctl, DN | PCM); end
    n_tests++;
    if (pc_sr !== 32'h0001_0024) begin
      n_fail++; $display("FAIL ret_pc: got %h want %h", pc_sr, 32'h0001_0024);
    end
    step();
    op_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ctl !== OPR) begin n_fail++; $display("FAIL ret_c3: got %h want %h", ctl, OPR); end
  endtask

  task automatic test_irq_during_ret();
    pc_value = 32'h0000_0100;
    step();
    op_valid = 1'b1;
    op_code  = OPC_CALL;
    step();
    step();
    op_code = OPC_RET;
    step();
    irq = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctl !== (STL | RD | POP | A_SP)) begin
      n_fail++; $display("FAIL irq_ret_c1: got %h want %h", ctl, STL | RD | POP | A_SP);
    end
    step();
    irq     = 1'b0;
    op_code = OPC_LOAD;
    @(negedge clk);
    n_tests++;
    if (ctl !== (DN | PCM)) begin n_fail++; $display("FAIL irq_ret_c2: got %h want %h", ctl, DN | PCM); end
    n_tests++;
    if (pc_sr !== 32'h0000_0100) begin
      n_fail++; $display("FAIL irq_ret_pc: got %h want %h", pc_sr, 32'h0000_0100);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (ctl !== (STL | WR | PSH | A_SP)) begin
      n_fail++; $display("FAIL int_c0: got %h want %h", ctl, STL | WR | PSH | A_SP);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (ctl !== (STL | WR | PSH | A_SP | S_PCU)) begin
      n_fail++; $display("FAIL int_c1: got %h want %h", ctl, STL | WR | PSH | A_SP | S_PCU);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (ctl !== (STL | WR | PSH | A_SP | S_PCL)) begin
      n_fail++; $display("FAIL int_c2: got %h want %h", ctl, STL | WR | PSH | A_SP | S_PCL);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (ctl !== (DN | INTR)) begin n_fail++; $display("FAIL int_c3: got %h want %h", ctl, DN | INTR); end
    step();
    @(negedge clk);
    n_tests++;
    if (ctl !== (OPR | DN | RD | A_LDD)) begin
      n_fail++; $display("FAIL held_op: got %h want %h", ctl, OPR | DN | RD | A_LDD);
    end
    step();
    op_valid = 1'b0;
    pc_value = 32'h7777_7777;
  endtask

  task automatic test_rti();
    int base;
    @(negedge clk);
    base = pop_total;
    step();
    op_valid = 1'b1;
    op_code  = OPC_RTI;
    @(negedge clk);
    n_tests++;
    if (ctl !== (OPR | STL | RD | POP | A_SP)) begin
      n_fail++; $display("FAIL rti_c0: got %h want %h", ctl, OPR | STL | RD | POP | A_SP);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (ctl !== (STL | RD | POP | A_SP)) begin
      n_fail++; $display("FAIL rti_c1: got %h want %h", ctl, STL | RD | POP | A_SP);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (ctl !== (DN | RD | POP | A_SP | PCM | FR)) begin
      n_fail++; $display("FAIL rti_c2: got %h want %h", ctl, DN | RD | POP | A_SP | PCM | FR);
    end
    n_tests++;
    if (pc_sr !== 32'h0000_0100) begin
      n_fail++; $display("FAIL rti_pc: got %h want %h", pc_sr, 32'h0000_0100);
    end
    step();
    op_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ((pop_total - base) !== 3) begin
      n_fail++; $display("FAIL rti_pops: got %0d want 3", pop_total - base);
    end
    n_tests++;
    if (flags_sr !== 16'h00A5) begin
      n_fail++; $display("FAIL rti_flags: got %h want %h", flags_sr, 16'h00A5);
    end
  endtask

  task automatic test_reset_mid_int();
    step();
    irq = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctl !== OPR) begin n_fail++; $display("FAIL irq_sample: got %h want %h", ctl, OPR); end
    step();
    irq = 1'b0;
    step();
    #1;
    n_tests++;
    if (ctl !== (STL | WR | PSH | A_SP | S_PCU)) begin
      n_fail++; $display("FAIL rst_int_c1: got %h want %h", ctl, STL | WR | PSH | A_SP | S_PCU);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (ctl !== OPR) begin n_fail++; $display("FAIL rst_async: got %h want %h", ctl, OPR); end
    @(negedge clk);
    n_tests++;
    if (ctl !== OPR) begin n_fail++; $display("FAIL rst_next: got %h want %h", ctl, OPR); end
    step();
    reset    = 1'b1;
    op_valid = 1'b1;
    op_code  = OPC_PUSH;
    @(negedge clk);
    n_tests++;
    if (ctl !== (OPR | DN | WR | PSH | A_SP | S_REG)) begin
      n_fail++; $display("FAIL rst_push: got %h want %h", ctl, OPR | DN | WR | PSH | A_SP | S_REG);
    end
    step();
    op_valid = 1'b0;
  endtask

  task automatic test_stack_boundary();
    step();
    op_valid = 1'b1;
    op_code  = OPC_POP;
    @(negedge clk);
    n_tests++;
    if (ctl !== (OPR | DN | RD | POP | A_SP)) begin
      n_fail++; $display("FAIL pop_last: got %h want %h", ctl, OPR | DN | RD | POP | A_SP);
    end
    step();
    @(negedge clk);
`ifdef MEM_SEQ_STACK_CHECK_EN
    n_tests++;
    if (ctl !== (OPR | DN | SF)) begin
      n_fail++; $display("FAIL pop_empty: got %h want %h", ctl, OPR | DN | SF);
    end
    step();
    op_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ctl !== (OPR | SF)) begin n_fail++; $display("FAIL fault_sticky: got %h want %h", ctl, OPR | SF); end
    step();
    op_valid = 1'b1;
    op_code  = OPC_PUSH;
    repeat (1024) step();
    @(negedge clk);
    n_tests++;
    if (ctl !== (OPR | DN | SF)) begin
      n_fail++; $display("FAIL push_full: got %h want %h", ctl, OPR | DN | SF);
    end
    step();
    op_code = OPC_POP;
    @(negedge clk);
    n_tests++;
    if (ctl !== (OPR | DN | RD | POP | A_SP | SF)) begin
      n_fail++; $display("FAIL pop_full: got %h want %h", ctl, OPR | DN | RD | POP | A_SP | SF);
    end
`else
    n_tests++;
    if (ctl !== (OPR | DN | RD | POP | A_SP)) begin
      n_fail++; $display("FAIL pop_empty: got %h want %h", ctl, OPR | DN | RD | POP | A_SP);
    end
    step();
    op_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ctl !== OPR) begin n_fail++; $display("FAIL no_fault: got %h want %h", ctl, OPR); end
`endif
    step();
    op_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_call();
    test_ret();
    test_irq_during_ret();
    test_rti();
    test_reset_mid_int();
    test_stack_boundary();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
